// File: rtl/apb_initiator_pkg.sv
// apb_initiator_pkg: shared APB requester types and default constants.
package apb_initiator_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_TIMEOUT_CYCLES = 256;
  typedef logic [APB_ADDR_W-1:0] apb_addr_t;
  typedef logic [APB_DATA_W-1:0] apb_data_t;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_init_state_t;
endpackage

// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB requester with wait-state timeout and misalign rejection.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  localparam int CNT_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              timeout;
  } rsp_t;
  apb_init_state_t state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic pwrite_q, pwrite_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  rsp_t rsp_q, rsp_d;
  logic misaligned;
  assign misaligned = |(cmd_addr & ALIGN_MASK);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    cnt_d = cnt_q;
    rsp_d = rsp_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        paddr_d = cmd_addr;
        pwdata_d = cmd_wdata;
        pwrite_d = cmd_write;
        cnt_d = '0;
        rsp_d = '{rdata: '0, err: misaligned, timeout: 1'b0};
        state_d = misaligned ? RESP : SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (pready) begin
        rsp_d = '{rdata: (pwrite_q | pslverr) ? '0 : prdata, err: pslverr, timeout: 1'b0};
        state_d = RESP;
      end else begin
        cnt_d = cnt_inc;
        // the cycle whose miss would bring the count to the limit is the last one waited
        if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_VAL) begin
          rsp_d = '{rdata: '0, err: 1'b1, timeout: 1'b1};
          state_d = RESP;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      paddr_q <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      cnt_q <= '0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      cnt_q <= cnt_d;
      rsp_q <= rsp_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign psel = state_q == SETUP || state_q == ACCESS;
  assign penable = state_q == ACCESS;
  assign rsp_valid = state_q == RESP;
  assign paddr = paddr_q;
  assign pwdata = pwdata_q;
  assign pwrite = pwrite_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: randomized transfers against a transaction-level timeline model of the requester.
module tb_apb_initiator;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata = 0;
  logic psel, penable, pwrite, pready = 0, pslverr = 0;
  int checks = 0, errors = 0;
  logic chk_en = 0;
  logic exp_ready, exp_psel, exp_pen, exp_rv, exp_err, exp_to, exp_write;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  int lat;
  logic got_err, got_to;
  logic [31:0] got_rdata;

  apb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    chk("psel", 32'(psel), 32'(exp_psel));
    chk("penable", 32'(penable), 32'(exp_pen));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    end
    if (exp_psel) begin
      chk("paddr", paddr, exp_addr);
      chk("pwrite", 32'(pwrite), 32'(exp_write));
      chk("pwdata", pwdata, exp_wdata);
    end
  end

  // Entered and left 1 time unit after a rising edge with the DUT idle; k counts cycles from acceptance.
  task automatic run(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int w,
                     input logic slv, input logic [31:0] trd, input int delay, input logic hold);
    logic mis, tmo;
    int a, r;
    mis = addr[1:0] != 2'b00;
    tmo = !mis && w >= TO;
    a = mis ? 0 : (tmo ? TO : w + 1);
    r = mis ? 1 : 2 + a;
    exp_err = mis || tmo || slv;
    exp_to = tmo;
    exp_rdata = (!wr && !exp_err) ? trd : 32'h0;
    exp_addr = addr;
    exp_wdata = wd;
    exp_write = wr;
    lat = -1;
    chk_en = 1;
    for (int k = 0; k <= r + delay; k++) begin
      if (rsp_valid && lat < 0) begin
        lat = k;
        got_err = rsp_err;
        got_to = rsp_timeout;
        got_rdata = rsp_rdata;
      end
      cmd_valid = (k == 0) || hold;
      cmd_write = (k == 0) ? wr : 1'($urandom);
      cmd_addr = (k == 0) ? addr : $urandom;
      cmd_wdata = (k == 0) ? wd : $urandom;
      if (!mis && k >= 2 && k < 2 + a) begin
        pready = (k - 2 == w);
        prdata = (k - 2 == w) ? trd : $urandom;
        pslverr = (k - 2 == w) ? slv : 1'($urandom);
      end else begin
        pready = 1'($urandom);
        prdata = $urandom;
        pslverr = 1'($urandom);
      end
      rsp_ready = (k == r + delay);
      exp_ready = (k == 0);
      exp_psel = !mis && k >= 1 && k < 2 + a;
      exp_pen = !mis && k >= 2 && k < 2 + a;
      exp_rv = k >= r;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    rsp_ready = 0;
    pready = 0;
  endtask

  initial begin
    logic [31:0] ra;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_psel", 32'(psel), 0);
    chk("reset_penable", 32'(penable), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_err", 32'(rsp_err), 0);
    chk("reset_rsp_timeout", 32'(rsp_timeout), 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    rst = 0;
    @(posedge clk); #1;
    run(1, 32'h10, 32'hA5A5_0001, 0, 0, 32'h0, 0, 0);
    chk("t1_latency", 32'(lat), 3);
    chk("t1_err", 32'(got_err), 0);
    run(0, 32'h04, 32'h0, 3, 0, 32'h1B45_F720, 0, 0);
    chk("t2_latency", 32'(lat), 6);
    chk("t2_rdata", got_rdata, 32'h1B45_F720);
    run(0, 32'h08, 32'h0, 1, 1, 32'hDEAD_BEEF, 1, 0);
    chk("t3_err", 32'(got_err), 1);
    chk("t3_timeout", 32'(got_to), 0);
    chk("t3_rdata", got_rdata, 0);
    run(0, 32'h0C, 32'h0, 40, 0, 32'h1234_5678, 0, 0);
    chk("t4_latency", 32'(lat), 10);
    chk("t4_timeout", 32'(got_to), 1);
    chk("t4_err", 32'(got_err), 1);
    run(0, 32'h0C, 32'h0, 0, 0, 32'h1234_5678, 0, 0);
    chk("t4_retry_latency", 32'(lat), 3);
    chk("t4_retry_rdata", got_rdata, 32'h1234_5678);
    run(0, 32'h06, 32'h0, 0, 0, 32'h0, 0, 0);
    chk("t5_latency", 32'(lat), 1);
    chk("t5_err", 32'(got_err), 1);
    run(1, 32'h40, 32'h0BAD_F00D, 2, 0, 32'h0, 5, 1);
    chk("t6_latency", 32'(lat), 5);
    run(0, 32'h44, 32'h0, TO - 1, 0, 32'hCAFE_0007, 0, 0);
    chk("edge_last_wait_wins", 32'(got_to), 0);
    chk("edge_last_wait_rdata", got_rdata, 32'hCAFE_0007);
    chk_en = 0;
    cmd_valid = 1;
    cmd_write = 0;
    cmd_addr = 32'h20;
    pready = 0;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    chk("mid_access_psel", 32'(psel), 1);
    chk("mid_access_penable", 32'(penable), 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_psel", 32'(psel), 0);
    chk("rst_mid_penable", 32'(penable), 0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 150; i++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) ra[1:0] = 2'($urandom_range(3, 1));
      run(1'($urandom), ra, $urandom, $urandom_range(11), $urandom_range(4) == 0, $urandom,
          $urandom_range(3), 1'($urandom));
    end
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
